// File: rtl/sample_stream_ctrl.sv
// sample_stream_ctrl: paced ROM-to-FIR sample sequencer with valid/ready output
module sample_stream_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 11416
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] num_samples,
  input  logic [7:0]        rate_div,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] x_out,
  output logic              x_valid,
  input  logic              x_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_t;
  localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);
  state_t state, next_state;
  logic [ADDR_W-1:0] addr, n, n_in, last_addr;
  logic [7:0] rd, div_cnt;
  logic go, hs, last;
  assign n_in = (num_samples > DEPTH_C) ? DEPTH_C : num_samples;
  assign go   = (state == IDLE) && start && !stop && (n_in != '0);
  assign hs   = (state == HOLD) && x_ready;
  assign last = addr == n - ADDR_W'(1);
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end
  // next-state: stop wins over everything, HOLD leaves only on a handshake
  always_comb begin
    next_state = state;
    if (stop) next_state = IDLE;
    else begin
      unique case (state)
        IDLE:  next_state = go ? FETCH : IDLE;
        FETCH: next_state = (div_cnt == 8'd0) ? LOAD : FETCH;
        LOAD:  next_state = HOLD;
        HOLD:  next_state = !x_ready ? HOLD : (last && !loop_en) ? IDLE : FETCH;
      endcase
    end
  end
  // outputs decoded from state: the read strobe depends only on registers, never on x_ready
  always_comb begin
    busy     = state != IDLE;
    rom_en   = (state == FETCH) && (div_cnt == 8'd0);
    rom_addr = rom_en ? addr : last_addr;
  end
  // datapath: address walk, pacing counter, sample register, pass accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      n         <= '0;
      rd        <= '0;
      div_cnt   <= '0;
      last_addr <= '0;
      x_out     <= '0;
      x_valid   <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done    <= 1'b0;
      div_cnt <= go ? 8'd0 : rom_en ? rd : (busy && div_cnt != 8'd0) ? div_cnt - 8'd1 : div_cnt;
      if (rom_en) last_addr <= addr;
      if (stop) x_valid <= 1'b0;
      else if (go) begin
        addr      <= '0;
        frame_cnt <= '0;
        n         <= n_in;
        rd        <= rate_div;
      end else if (state == LOAD) begin
        x_out   <= rom_data;
        x_valid <= 1'b1;
      end else if (hs) begin
        x_valid <= 1'b0;
        addr    <= last ? '0 : addr + ADDR_W'(1);
        if (last) frame_cnt <= frame_cnt + 16'd1;
        done    <= last && !loop_en;
      end
    end
  end
endmodule

// File: tb/tb_sample_stream_ctrl.sv
// tb_sample_stream_ctrl: scoreboard bench for sample_stream_ctrl
module tb_sample_stream_ctrl;
  logic clk = 0, rst = 1, start = 0, stop = 0, loop_en = 0, x_ready = 1;
  logic [13:0] num_samples = 0, rom_addr;
  logic [7:0] rate_div = 0;
  logic rom_en, x_valid, busy, done;
  logic [15:0] rom_data = 0, x_out, frame_cnt;
  logic [15:0] rom [0:15];
  int tests = 0, fails = 0, cyc = 0, hs_cnt = 0, t0, ne;
  logic [13:0] exp_addr [$];
  logic [15:0] exp_data [$];
  int en_cyc [$];
  logic pv = 0, pr = 0, pblk = 0;
  logic [15:0] px = 0;

  sample_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .num_samples(num_samples), .rate_div(rate_div), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .x_out(x_out), .x_valid(x_valid),
    .x_ready(x_ready), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_en) rom_data <= rom[rom_addr[3:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rom_en) begin
      en_cyc.push_back(cyc);
      if (exp_addr.size() == 0) chk("fetch_expected", 1, 0);
      else chk("rom_addr", 32'(rom_addr), 32'(exp_addr.pop_front()));
    end
    if (x_valid && x_ready && !stop && !rst) begin
      hs_cnt++;
      if (exp_data.size() == 0) chk("sample_expected", 1, 0);
      else chk("x_out", 32'(x_out), 32'(exp_data.pop_front()));
    end
    if (pv && !pr && !pblk) begin
      chk("hold_valid", 32'(x_valid), 1);
      chk("hold_data", 32'(x_out), 32'(px));
    end
    if (done) chk("done_excl_valid", 32'(x_valid), 0);
    pv = x_valid; pr = x_ready; pblk = stop || rst; px = x_out;
  end

  task automatic tick(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic kick(input logic [13:0] n, input logic [7:0] r, input logic lp, output int t);
    num_samples = n; rate_div = r; loop_en = lp; start = 1; t = cyc;
    en_cyc.delete();
    tick(1);
    start = 0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 400) begin tick(1); k++; end
    chk(nm, 32'(busy), 0);
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (hs_cnt < target && k < 200) begin tick(1); k++; end
    chk("hs_reached", 32'(hs_cnt >= target), 1);
  endtask

  task automatic push(input logic [13:0] a);
    exp_addr.push_back(a);
  endtask

  task automatic queues_empty();
    chk("addr_q_empty", exp_addr.size(), 0);
    chk("data_q_empty", exp_data.size(), 0);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_rom_en"}, 32'(rom_en), 0);
    chk({nm, "_rom_addr"}, 32'(rom_addr), 0);
    chk({nm, "_x_out"}, 32'(x_out), 0);
    chk({nm, "_x_valid"}, 32'(x_valid), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_frame_cnt"}, 32'(frame_cnt), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'(i + 1);
    tick(3);
    reset_vals("rst");
    rst = 0;
    tick(1);
    reset_vals("post_rst");
    // basic pass, fastest rate
    for (int a = 0; a < 4; a++) begin push(14'(a)); exp_data.push_back(16'(a + 1)); end
    kick(4, 0, 0, t0);
    wait_idle("t1_idle");
    chk("t1_done", 32'(done), 1);
    chk("t1_frame", 32'(frame_cnt), 1);
    chk("t1_fetches", en_cyc.size(), 4);
    for (int i = 0; i < 4 && i < en_cyc.size(); i++) chk("t1_fetch_cycle", en_cyc[i] - t0, 1 + 3 * i);
    tick(1);
    chk("t1_done_pulse", 32'(done), 0);
    queues_empty();
    // slow rate
    for (int a = 0; a < 4; a++) begin push(14'(a)); exp_data.push_back(16'(a + 1)); end
    kick(4, 9, 0, t0);
    wait_idle("t2_idle");
    chk("t2_done", 32'(done), 1);
    chk("t2_fetches", en_cyc.size(), 4);
    for (int i = 0; i < 4 && i < en_cyc.size(); i++) chk("t2_fetch_cycle", en_cyc[i] - t0, 1 + 10 * i);
    queues_empty();
    // backpressure on the second sample
    for (int a = 0; a < 4; a++) begin push(14'(a)); exp_data.push_back(16'(a + 1)); end
    kick(4, 0, 0, t0);
    tick(3);
    x_ready = 0;
    for (int k = 0; k < 20 && !x_valid; k++) tick(1);
    chk("bp_valid", 32'(x_valid), 1);
    chk("bp_data", 32'(x_out), 2);
    ne = en_cyc.size();
    tick(7);
    chk("bp_no_fetch", en_cyc.size(), ne);
    x_ready = 1;
    wait_idle("t3_idle");
    chk("t3_done", 32'(done), 1);
    chk("t3_frame", 32'(frame_cnt), 1);
    queues_empty();
    // looping, then loop_en cleared during the third pass
    for (int p = 0; p < 3; p++)
      for (int a = 0; a < 3; a++) begin push(14'(a)); exp_data.push_back(16'(a + 1)); end
    ne = hs_cnt;
    kick(3, 0, 1, t0);
    wait_hs(ne + 3);
    chk("t4_frame1", 32'(frame_cnt), 1);
    wait_hs(ne + 6);
    chk("t4_frame2", 32'(frame_cnt), 2);
    wait_hs(ne + 7);
    loop_en = 0;
    wait_idle("t4_idle");
    chk("t4_done", 32'(done), 1);
    chk("t4_frame3", 32'(frame_cnt), 3);
    queues_empty();
    // stop in HOLD with a same-cycle handshake
    push(0); push(1); push(0); push(1);
    exp_data.push_back(1); exp_data.push_back(2); exp_data.push_back(1);
    kick(2, 0, 1, t0);
    tick(11);
    chk("t5_valid", 32'(x_valid), 1);
    chk("t5_frame_pre", 32'(frame_cnt), 1);
    stop = 1;
    tick(1);
    stop = 0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid_off", 32'(x_valid), 0);
    chk("t5_no_done", 32'(done), 0);
    chk("t5_frame", 32'(frame_cnt), 1);
    chk("t5_rom_en", 32'(rom_en), 0);
    chk("t5_x_keep", 32'(x_out), 2);
    queues_empty();
    loop_en = 0;
    push(0); push(1); exp_data.push_back(1); exp_data.push_back(2);
    kick(2, 0, 0, t0);
    wait_idle("t5_replay_idle");
    chk("t5_replay_done", 32'(done), 1);
    chk("t5_replay_frame", 32'(frame_cnt), 1);
    queues_empty();
    // reset mid-run, then a zero-length start
    push(0); push(1); exp_data.push_back(1);
    kick(2, 0, 1, t0);
    tick(5);
    chk("t6_valid", 32'(x_valid), 1);
    chk("t6_addr", 32'(rom_addr), 1);
    rst = 1;
    tick(1);
    rst = 0;
    reset_vals("t6");
    queues_empty();
    loop_en = 0;
    num_samples = 0; start = 1;
    tick(1);
    start = 0;
    chk("t6_zero_busy", 32'(busy), 0);
    chk("t6_zero_rom_en", 32'(rom_en), 0);
    tick(2);
    chk("t6_zero_busy_late", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sample_stream_ctrl.md
# sample_stream_ctrl

Sequencer between the input-sample ROM and the FIR filter input of each filter build (LPF/HPF/BPF/BSF). On a start command it steps the ROM address, absorbs the ROM's one-cycle read latency, paces samples at a programmable rate and presents them on a valid/ready handshake. It supports single-shot or looped playback, abort, and pass counting. It replaces free-running address generation, so the filter can be stalled, re-triggered and throttled without touching the ROM contents.

## Interface
- ADDR_W, 14, ROM address width
- DATA_W, 16, sample width (two's complement)
- DEPTH, 11416, ROM words; upper bound for num_samples
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin playback (pulse; level also accepted, edge not required)
- stop  in  1  abort playback
- loop_en  in  1  restart from address 0 after last sample (read live)
- num_samples  in  ADDR_W  samples per pass; latched at start
- rate_div  in  8  sample period = max(rate_div+1, 3) cycles; latched at start
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  DATA_W  ROM output, valid the cycle after rom_en
- x_out  out  DATA_W  sample to FIR (signed)
- x_valid  out  1  x_out valid
- x_ready  in  1  FIR accepts sample
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of a non-looped pass
- frame_cnt  out  16  completed passes since last start

## Operation
- States: IDLE, FETCH, LOAD, HOLD.
- IDLE
  - start with latched count n≠0 and stop=0 → addr=0, clear frame_cnt, div_cnt=0, go to FETCH.
  - start with n=0 is ignored.
  - num_samples > DEPTH is clamped to DEPTH at latch.
- FETCH: when div_cnt==0 → rom_en=1, rom_addr=addr, div_cnt←rate_div, go to LOAD. Otherwise wait.
- LOAD: x_out←rom_data, x_valid←1, go to HOLD.
- HOLD: x_valid held, x_out stable until x_ready=1. On the handshake:
  - x_valid←0.
  - If addr<n-1 → addr+1, go to FETCH.
  - If addr==n-1 → frame_cnt+1 (wraps at 16 bits). Then if loop_en → addr=0, go to FETCH; otherwise done←1, go to IDLE.
- div_cnt decrements (saturating at 0) every cycle outside IDLE, except in the cycle it is reloaded.
- stop in any non-IDLE state → IDLE next cycle, x_valid←0, rom_en←0, no done pulse, frame_cnt unchanged. stop has priority over a same-cycle handshake or start.
- start while busy is ignored; latched parameters are not updated.
- Clearing loop_en mid-pass finishes the current pass, then ends with done.
- rom_en is low in every state except FETCH-with-issue. rom_addr holds its last value.

## Timing
- Reset values: rom_en=0, rom_addr=0, x_out=0, x_valid=0, busy=0, done=0, frame_cnt=0. Internal state is IDLE, addr=0, div_cnt=0.
- Latency: start at cycle 0 → busy=1 and rom_en=1 at cycle 1 → x_valid=1 at cycle 3.
- With x_ready tied high, one sample is accepted every max(rate_div+1, 3) cycles.
- x_ready low stretches HOLD indefinitely. The next fetch is not issued before the handshake, and div_cnt keeps counting meanwhile.
- done and busy=0 appear in the cycle after the final handshake. done is never asserted with x_valid.
- x_out retains the last sample after x_valid drops.
- No combinational path from x_ready to x_valid or to rom_en.

## Test plan
- n=4, rate_div=0, x_ready=1, ROM words 0x0001..0x0004: rom_en pulses at cycles 1, 4, 7, 10 with addr 0..3. Four handshakes return 0x0001..0x0004 in order. done pulses once, frame_cnt=1, busy falls.
- n=4, rate_div=9: consecutive rom_en pulses are exactly 10 cycles apart, and the output sequence is unchanged.
- Backpressure: hold x_ready=0 for 7 cycles on the second sample. x_valid and x_out stay stable, no extra rom_en, no sample lost or repeated.
- loop_en=1, n=3: address sequence 0,1,2,0,1,2, and frame_cnt increments after each addr-2 handshake. Clear loop_en during the third pass: that pass completes, done pulses, frame_cnt=3.
- stop asserted in HOLD with x_ready=1 in the same cycle: IDLE next cycle, x_valid=0, no done, frame_cnt unchanged. A new start replays from addr 0.
- rst asserted mid-run, plus start with num_samples=0: all outputs return to reset values the next cycle. The zero-length start leaves busy=0 and rom_en=0.
